// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared types and constants for the NPC fetch path
package npc_pkg;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT_RSP,
        HOLD,
        HALT
    } fetch_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencing and IMEM fetch handshake for the NPC core
module fetch_sequencer
    import npc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  pc_q,
    output logic              pc_wen,
    output logic              pc_jen,
    output logic [WIDTH-1:0]  pc_din,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WIDTH-1:0]  imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [WIDTH-1:0]  inst_pc,
    input  logic              redir_valid,
    input  logic [WIDTH-1:0]  redir_target,
    input  logic              halt_req,
    output logic              halted,
    output logic [CNT_W-1:0]  inst_cnt
);

    fetch_state_e      state_q;
    logic              redir_pend_q;
    logic              halt_pend_q;
    logic [WIDTH-1:0]  pend_tgt_q;
    logic [WIDTH-1:0]  inst_pc_q;
    logic [INST_W-1:0] inst_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              commit;

    assign commit         = (state_q == HOLD) && inst_ready;
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == HOLD);
    assign halted         = (state_q == HALT);
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign inst_cnt       = cnt_q;
    assign pc_wen         = commit;
    assign pc_jen         = commit && (redir_valid || redir_pend_q);

    // A live redirect beats the buffered one; the sequential value is shown only for a plain commit.
    always_comb begin
        pc_din = pend_tgt_q;
        if (commit) begin
            if (redir_valid)
                pc_din = redir_target;
            else if (!redir_pend_q)
                pc_din = inst_pc_q + WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            redir_pend_q <= 1'b0;
            halt_pend_q  <= 1'b0;
            pend_tgt_q   <= '0;
            inst_pc_q    <= '0;
            inst_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                BOOT:     state_q <= REQ;
                REQ:      if (imem_req_ready) state_q <= WAIT_RSP;
                WAIT_RSP: begin
                    // pc_q cannot move before commit, so it is still the requested address
                    if (imem_rsp_valid) begin
                        state_q     <= HOLD;
                        inst_data_q <= imem_rsp_data;
                        inst_pc_q   <= pc_q;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        state_q <= (halt_req || halt_pend_q) ? HALT : REQ;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                HALT:     state_q <= HALT;
                default:  state_q <= BOOT;
            endcase

            if (state_q != HALT) begin
                if (commit) begin
                    redir_pend_q <= 1'b0;
                    pend_tgt_q   <= '0;
                end else if (redir_valid) begin
                    redir_pend_q <= 1'b1;
                    pend_tgt_q   <= redir_target;
                end
                if (!commit && halt_req)
                    halt_pend_q <= 1'b1;
            end
        end
    end

endmodule
